// File: rtl/position_ring_scheduler.sv
// position_ring_scheduler
//
// Sequences one timestep loop of the position ring. It broadcasts a node
// command (dispatch) and the BRAM bank select (double_buffer) to every ring
// node. It watches the nodes' wired-AND/OR completion flags to decide when a
// neighbor batch has finished circulating. It then advances batches and
// timesteps, and aborts a run when a batch overstays its watchdog budget.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low; clears all state immediately
//   start          begin a run (honoured only in IDLE, and only without abort)
//   abort          synchronous abort request, effective in any busy state
//   num_steps      timesteps per run, latched on accepted start (0 means 1)
//   done_batch     per-node reference stream exhausted
//   done_all       per-node neighbor cell exhausted
//   in_flight      per-node particle currently on a ring link
//   dispatch       node command: 11 clear, 01 load batch, 10 run/hold
//   double_buffer  node BRAM bank select; persists across runs
//   busy           high in every state except IDLE
//   step_done      one-cycle pulse per completed timestep
//   run_done       one-cycle pulse when the last timestep completes
//   error          sticky watchdog flag, cleared by the next accepted start
//   step_count     timesteps completed this run
//   batch_count    load dispatches issued this run
module position_ring_scheduler #(
  parameter int NNODES    = 8,
  parameter int TIMEOUT   = 4096,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       num_steps,
  input  logic [NNODES-1:0] done_batch,
  input  logic [NNODES-1:0] done_all,
  input  logic [NNODES-1:0] in_flight,
  output logic [1:0]        dispatch,
  output logic              double_buffer,
  output logic              busy,
  output logic              step_done,
  output logic              run_done,
  output logic              error,
  output logic [15:0]       step_count,
  output logic [15:0]       batch_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int HD_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(FLUSH_CYC - 1);

  localparam logic [1:0] DISP_CLEAR = 2'b11;
  localparam logic [1:0] DISP_LOAD  = 2'b01;
  localparam logic [1:0] DISP_RUN   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_FLUSH, S_HOLD, S_SWAP, S_ABORT
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       num_q, num_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [HD_W-1:0]   hold_q, hold_d;
  logic [1:0]        dispatch_q, dispatch_d;
  logic              dbuf_q, dbuf_d;
  logic              busy_q, busy_d;
  logic              step_done_q, step_done_d;
  logic              run_done_q, run_done_d;
  logic              error_q, error_d;
  logic [15:0]       step_q, step_d;
  logic [15:0]       batch_q, batch_d;

  logic              batch_exit;
  logic              all_done;
  logic [15:0]       step_inc;

  // A batch is finished once every node has drained its reference stream
  // and no particle is still travelling between nodes.
  assign batch_exit = (&done_batch) && !(|in_flight);
  assign all_done   = &done_all;
  assign step_inc   = step_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    wd_d        = wd_q;
    hold_d      = hold_q;
    dbuf_d      = dbuf_q;
    step_done_d = 1'b0;
    run_done_d  = 1'b0;
    error_d     = error_q;
    step_d      = step_q;
    batch_d     = batch_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_CLEAR;
          num_d   = (num_steps == 16'd0) ? 16'd1 : num_steps;
          step_d  = 16'd0;
          batch_d = 16'd0;
          error_d = 1'b0;
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN: begin
        wd_d = wd_q + 1'b1;
        // wd_q is zero only in the first RUN cycle, where node flags still
        // reflect the pre-load state and must not be trusted.
        if ((wd_q != '0) && batch_exit) begin
          state_d = all_done ? S_FLUSH : S_LOAD;
        end else if (wd_q == WD_LAST) begin
          error_d = 1'b1;
          state_d = S_ABORT;
        end
      end
      S_FLUSH: begin
        state_d = S_HOLD;
        hold_d  = '0;
      end
      S_HOLD: begin
        if (hold_q == HD_LAST) state_d = S_SWAP;
        else                   hold_d  = hold_q + 1'b1;
      end
      S_SWAP: begin
        dbuf_d      = ~dbuf_q;
        step_d      = step_inc;
        step_done_d = 1'b1;
        if (step_inc == num_q) begin
          run_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a completing SWAP: the bank is
    // not flipped and the step is not counted.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_ABORT;
      dbuf_d      = dbuf_q;
      step_d      = step_q;
      step_done_d = 1'b0;
      run_done_d  = 1'b0;
    end

    if (state_d == S_LOAD) begin
      batch_d = batch_q + 16'd1;
      wd_d    = '0;
    end

    // Outputs are registered from the next state so each state's command
    // is on the wire during the very cycle that state is occupied.
    case (state_d)
      S_CLEAR, S_ABORT: dispatch_d = DISP_CLEAR;
      S_LOAD, S_FLUSH:  dispatch_d = DISP_LOAD;
      default:          dispatch_d = DISP_RUN;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      num_q       <= 16'd1;
      wd_q        <= '0;
      hold_q      <= '0;
      dispatch_q  <= DISP_RUN;
      dbuf_q      <= 1'b0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      run_done_q  <= 1'b0;
      error_q     <= 1'b0;
      step_q      <= 16'd0;
      batch_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      wd_q        <= wd_d;
      hold_q      <= hold_d;
      dispatch_q  <= dispatch_d;
      dbuf_q      <= dbuf_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      run_done_q  <= run_done_d;
      error_q     <= error_d;
      step_q      <= step_d;
      batch_q     <= batch_d;
    end
  end

  assign dispatch      = dispatch_q;
  assign double_buffer = dbuf_q;
  assign busy          = busy_q;
  assign step_done     = step_done_q;
  assign run_done      = run_done_q;
  assign error         = error_q;
  assign step_count    = step_q;
  assign batch_count   = batch_q;

endmodule

// File: tb/tb_position_ring_scheduler.sv
// Testbench for position_ring_scheduler. Directed stimulus drives the ring
// flags cycle by cycle. Every expected timestep completion is queued when
// its run is launched, and a monitor checks each step_done/run_done event
// against the head of that queue.
module tb_position_ring_scheduler;

  localparam int NN = 8;
  localparam int TO = 16;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [15:0]   num_steps;
  logic [NN-1:0] done_batch;
  logic [NN-1:0] done_all;
  logic [NN-1:0] in_flight;
  logic [1:0]    dispatch;
  logic          double_buffer;
  logic          busy;
  logic          step_done;
  logic          run_done;
  logic          error;
  logic [15:0]   step_count;
  logic [15:0]   batch_count;

  position_ring_scheduler #(.NNODES(NN), .TIMEOUT(TO), .FLUSH_CYC(FC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_steps(num_steps), .done_batch(done_batch), .done_all(done_all),
    .in_flight(in_flight), .dispatch(dispatch), .double_buffer(double_buffer),
    .busy(busy), .step_done(step_done), .run_done(run_done), .error(error),
    .step_count(step_count), .batch_count(batch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sc;
    logic [15:0] bc;
    logic        db;
    logic        rd;
  } ev_t;

  ev_t  sb[$];
  ev_t  mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  logic exp_db;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic [15:0] sc, input logic [15:0] bc,
                         input logic db, input logic rd);
    ev_t e;
    e.sc = sc; e.bc = bc; e.db = db; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_dispatch"}, dispatch, 2'b10);
    chk({pfx, "_dbuf"}, double_buffer, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_step_done"}, step_done, 0);
    chk({pfx, "_run_done"}, run_done, 0);
    chk({pfx, "_error"}, error, 0);
    chk({pfx, "_step_count"}, step_count, 0);
    chk({pfx, "_batch_count"}, batch_count, 0);
  endtask

  // Starts in the first RUN cycle of a step; ends in the cycle after SWAP.
  task automatic run_tail(input int nb);
    for (int b = 0; b < nb; b++) begin
      chk("run1_dispatch", dispatch, 2'b10);
      tick();
      done_batch = {NN{1'b1}};
      done_all   = (b == nb - 1) ? {NN{1'b1}} : {NN{1'b0}};
      in_flight  = '0;
      chk("run2_dispatch", dispatch, 2'b10);
      tick();
      done_batch = '0;
      done_all   = '0;
      chk("load_or_flush_dispatch", dispatch, 2'b01);
      tick();
    end
    for (int h = 0; h < FC; h++) begin
      chk("hold_dispatch", dispatch, 2'b10);
      tick();
    end
    chk("swap_dispatch", dispatch, 2'b10);
    chk("swap_busy", busy, 1);
    tick();
  endtask

  // Starts in the CLEAR cycle.
  task automatic do_step(input int nb);
    chk("clear_dispatch", dispatch, 2'b11);
    tick();
    chk("load_dispatch", dispatch, 2'b01);
    tick();
    run_tail(nb);
  endtask

  task automatic launch(input logic [15:0] ns);
    num_steps = ns;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && (step_done || run_done)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL step_event_unexpected: step_done=%0b run_done=%0b with nothing expected at %0t",
                 step_done, run_done, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("ev_step_done", step_done, 1);
        chk("ev_run_done", run_done, mon_e.rd);
        chk("ev_step_count", step_count, mon_e.sc);
        chk("ev_batch_count", batch_count, mon_e.bc);
        chk("ev_dbuf", double_buffer, mon_e.db);
      end
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; num_steps = 16'd0;
    done_batch = '0; done_all = '0; in_flight = '0;

    // Reset held while start toggles.
    for (int i = 0; i < 4; i++) begin
      tick();
      start = ~start;
    end
    chk_reset_vals("in_reset");
    start = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    chk_reset_vals("post_reset");

    // Single step, single batch.
    exp_db = 1'b1;
    push_ev(16'd1, 16'd1, exp_db, 1'b1);
    launch(16'd1);
    do_step(1);
    chk("t1_busy", busy, 0);
    chk("t1_dbuf", double_buffer, exp_db);
    chk("t1_batch", batch_count, 1);
    tick();
    chk("t1_pulse_gone", {step_done, run_done}, 2'b00);

    // Multi-batch from a fresh bank select.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    chk("t2_dbuf_reset", double_buffer, 0);
    push_ev(16'd1, 16'd3, 1'b1, 1'b0);
    push_ev(16'd2, 16'd6, 1'b0, 1'b0);
    push_ev(16'd3, 16'd9, 1'b1, 1'b1);
    exp_db = 1'b1;
    launch(16'd3);
    for (int s = 0; s < 3; s++) do_step(3);
    chk("t2_busy", busy, 0);
    chk("t2_step", step_count, 3);
    chk("t2_batch", batch_count, 9);
    chk("t2_dbuf", double_buffer, 1);

    // in_flight keeps the batch in RUN.
    exp_db = ~exp_db;
    push_ev(16'd1, 16'd2, exp_db, 1'b1);
    launch(16'd1);
    chk("t3_clear", dispatch, 2'b11);
    tick();
    chk("t3_load", dispatch, 2'b01);
    tick();
    chk("t3_run1", dispatch, 2'b10);
    tick();
    done_batch = {NN{1'b1}};
    done_all   = '0;
    in_flight  = 8'h04;
    for (int i = 0; i < 10; i++) begin
      chk("t3_inflight_hold", dispatch, 2'b10);
      tick();
    end
    in_flight = '0;
    chk("t3_inflight_clear", dispatch, 2'b10);
    tick();
    chk("t3_load_after", dispatch, 2'b01);
    done_batch = '0;
    tick();
    run_tail(1);
    chk("t3_busy", busy, 0);

    // Watchdog expiry.
    launch(16'd1);
    chk("t4_clear", dispatch, 2'b11);
    tick();
    chk("t4_load", dispatch, 2'b01);
    tick();
    for (int i = 0; i < TO; i++) begin
      chk("t4_run", dispatch, 2'b10);
      chk("t4_no_error", error, 0);
      tick();
    end
    chk("t4_abort_dispatch", dispatch, 2'b11);
    chk("t4_error", error, 1);
    chk("t4_abort_busy", busy, 1);
    tick();
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_dispatch", dispatch, 2'b10);
    chk("t4_error_sticky", error, 1);
    chk("t4_step", step_count, 0);
    chk("t4_batch", batch_count, 1);
    chk("t4_dbuf", double_buffer, exp_db);

    // abort in IDLE masks start.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_abort_idle_busy", busy, 0);
    chk("t5_abort_idle_error", error, 1);
    tick();

    // New start clears error; abort during HOLD.
    launch(16'd2);
    chk("t6_error_cleared", error, 0);
    chk("t6_clear", dispatch, 2'b11);
    tick();
    chk("t6_load", dispatch, 2'b01);
    tick();
    chk("t6_run1", dispatch, 2'b10);
    tick();
    done_batch = {NN{1'b1}}; done_all = {NN{1'b1}};
    tick();
    done_batch = '0; done_all = '0;
    chk("t6_flush", dispatch, 2'b01);
    tick();
    chk("t6_hold", dispatch, 2'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_dispatch", dispatch, 2'b11);
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_dbuf", double_buffer, exp_db);
    chk("t6_step", step_count, 0);
    chk("t6_batch", batch_count, 1);
    chk("t6_no_step_done", step_done, 0);

    // num_steps=0 behaves as one step.
    exp_db = ~exp_db;
    push_ev(16'd1, 16'd1, exp_db, 1'b1);
    launch(16'd0);
    do_step(1);
    chk("t7_busy", busy, 0);
    chk("t7_step", step_count, 1);

    // Asynchronous reset mid-run.
    launch(16'd1);
    tick();
    tick();
    chk("t8_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk) reset = 1'b1;
    tick();
    chk("t8_idle_after", busy, 0);

    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/position_ring_scheduler.md
# position_ring_scheduler

Sequences one timestep loop of the position ring. Drives the broadcast `dispatch` code and `double_buffer` select into all NNODES position ring nodes. Collects each node's `done_batch`, `done_all` and `in_flight` flags to decide when a neighbor batch has finished circulating. Advances batches and timesteps, and aborts on a watchdog timeout. Sits between the host/top-level control and the ring.

## Interface
Parameters:
- NNODES, 8, number of ring nodes monitored
- TIMEOUT, 4096, maximum cycles allowed in RUN per batch before error
- FLUSH_CYC, 2, cycles held after the final flush dispatch so the force stage consumes the last neighbor set

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0), clears all state immediately
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  synchronous abort request, any state
- num_steps  in  16  timesteps per run, latched on accepted start; 0 treated as 1
- done_batch  in  NNODES  per-node reference stream exhausted
- done_all  in  NNODES  per-node neighbor cell exhausted
- in_flight  in  NNODES  per-node particle currently on ring link
- dispatch  out  2  broadcast node command: 2'b11 clear, 2'b01 load batch, 2'b10 run/hold (2'b00 never driven)
- double_buffer  out  1  bank select for node BRAM halves
- busy  out  1  high in every state except IDLE
- step_done  out  1  one-cycle pulse per completed timestep
- run_done  out  1  one-cycle pulse when last timestep completes
- error  out  1  sticky watchdog flag; cleared on next accepted start
- step_count  out  16  timesteps completed this run
- batch_count  out  16  load dispatches issued this run

## Operation
- All outputs registered, Moore-style; each state's `dispatch` value appears in the cycle the state is occupied.
- States:
  - IDLE: dispatch=10. On start & ~abort: latch num_steps; zero step_count, batch_count, error. Go to CLEAR.
  - CLEAR: dispatch=11 for 1 cycle, then LOAD.
  - LOAD: dispatch=01 for 1 cycle; batch_count+1; watchdog cleared. Then RUN.
  - RUN: dispatch=10; watchdog+1 each cycle.
    - Exit condition: &done_batch & ~|in_flight, evaluated from the 2nd RUN cycle onward.
    - If the exit condition holds and &done_all: go to FLUSH.
    - If the exit condition holds and not &done_all: go to LOAD.
    - If the watchdog reaches TIMEOUT-1 first: set error, go to ABORT.
  - FLUSH: dispatch=01 for 1 cycle, then HOLD.
  - HOLD: dispatch=10 for FLUSH_CYC cycles, then SWAP.
  - SWAP: toggle double_buffer; step_count+1; pulse step_done.
    - If the new step_count == latched num_steps: pulse run_done, go to IDLE.
    - Otherwise go to CLEAR.
  - ABORT: dispatch=11 for 1 cycle, then IDLE. double_buffer is not toggled; counts are held.
- abort in any non-IDLE state: go to ABORT next cycle, overriding all other transitions, including SWAP completion. abort in IDLE: start is ignored.
- start while busy is ignored.
- Counters wrap at 2^16 with no flag.
- double_buffer persists across runs; it is cleared only by reset.
- `done_*` and `in_flight` are used as flat wired AND/OR; no per-node masking.

## Timing
- Reset values: dispatch=2'b10, double_buffer=0, busy=0, step_done=0, run_done=0, error=0, step_count=0, batch_count=0, state IDLE.
- start high at edge k gives dispatch=11 in cycle k+1, dispatch=01 in cycle k+2, and RUN from cycle k+3.
- The first RUN cycle never exits, because node flags are cleared by the LOAD edge.
- Minimum batch period: 1 LOAD + 2 RUN = 3 cycles.
- Minimum timestep: CLEAR + LOAD + 2 RUN + FLUSH + FLUSH_CYC + SWAP = 6+FLUSH_CYC cycles.
- step_done and run_done are high during the cycle after SWAP's edge, for exactly 1 cycle.
- Reset asserted mid-run: outputs go to reset values immediately, asynchronously, without an ABORT clear cycle.

## Test plan
- Reset checks:
  - Hold reset=0, then release → all outputs at reset values.
  - Toggling start while reset=0 has no effect.
- Single step, single batch, NNODES=8, num_steps=1:
  - Stimulus: start; in the 2nd RUN cycle drive done_batch=done_all=8'hFF, in_flight=0.
  - Response: dispatch sequence 11,01,10,10,01,10,10,(SWAP); step_done and run_done pulse together; double_buffer=1; batch_count=1.
- Multi-batch, num_steps=3:
  - Stimulus: done_all set only on the 3rd exit condition each step.
  - Response: batch_count=9; step_count goes 1,2,3; double_buffer ends at 1; run_done pulses once.
- in_flight gating:
  - Stimulus: done_batch=FF but in_flight=8'h04 for 10 cycles.
  - Response: stays in RUN with dispatch=10; LOAD follows 1 cycle after in_flight clears.
- Watchdog, TIMEOUT=16:
  - Stimulus: never assert done_batch.
  - Response: error=1 after 16 RUN cycles; one dispatch=11 cycle; IDLE with busy=0.
  - A new start clears error.
- Abort and num_steps=0:
  - Abort during HOLD → ABORT, then IDLE; double_buffer unchanged; no step_done.
  - num_steps=0 behaves as 1: run_done follows the first SWAP.
